// File: rtl/bus_timer_slave_pkg.sv
// Shared constants for the bus timer slave: bus widths, register offsets,
// CTRL bit positions and handshake FSM states.
package bus_timer_slave_pkg;

    localparam int WORDSIZE = 32;
    localparam int ADDRSIZE = 32;

    localparam logic [7:0] TMR_CTRL     = 8'd0;
    localparam logic [7:0] TMR_LOAD     = 8'd1;
    localparam logic [7:0] TMR_COUNT    = 8'd2;
    localparam logic [7:0] TMR_STATUS   = 8'd3;
    localparam logic [7:0] TMR_PRESCALE = 8'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/bus_timer_slave_if.sv
// Slave-port bundle of the system bus: hello/we/addr/data from the
// interconnect, data/ack back to it.
interface bus_timer_slave_if;
    import bus_timer_slave_pkg::*;

    logic                hello_i;
    logic                we_i;
    logic [ADDRSIZE-1:0] addr_i;
    logic [WORDSIZE-1:0] data_i;
    logic [WORDSIZE-1:0] data_o;
    logic                ack_o;

    modport master (
        output hello_i, we_i, addr_i, data_i,
        input  data_o, ack_o
    );

    modport slave (
        input  hello_i, we_i, addr_i, data_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/bus_timer_slave_timer_counter.sv
// Down counter with reload and expiry pulse; optional prescaler when
// TIMER_PRESCALER_EN is defined.
module timer_counter
    import bus_timer_slave_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                auto,
    input  logic [WORDSIZE-1:0] load,
    input  logic                wr_count,
    input  logic [WORDSIZE-1:0] wr_value,
`ifdef TIMER_PRESCALER_EN
    input  logic [WORDSIZE-1:0] prescale,
    input  logic                wr_prescale,
`endif
    output logic [WORDSIZE-1:0] count,
    output logic                expire
);
    logic [WORDSIZE-1:0] count_reg, count_next;
    logic                step;

`ifdef TIMER_PRESCALER_EN
    logic [WORDSIZE-1:0] pre_reg, pre_next;

    assign step = (pre_reg == prescale);

    always_comb begin
        pre_next = pre_reg + 1'b1;
        if (!en || wr_prescale || step)
            pre_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pre_reg <= '0;
        else
            pre_reg <= pre_next;
    end
`else
    assign step = 1'b1;
`endif

    assign expire = en && step && (count_reg == '0);

    // A bus write to COUNT overrides any decrement or reload on the same edge.
    always_comb begin
        count_next = count_reg;
        if (en && step) begin
            if (count_reg != '0)
                count_next = count_reg - 1'b1;
            else if (auto)
                count_next = load;
        end
        if (wr_count)
            count_next = wr_value;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign count = count_reg;
endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped down-counting timer on a 4-phase bus slave port.
// Optional PRESCALE register at offset 4 when TIMER_PRESCALER_EN is defined.
module bus_timer_slave
    import bus_timer_slave_pkg::*;
#(
    parameter int                  OFFSET_BITS = 3,
    parameter logic [WORDSIZE-1:0] RESET_LOAD  = '0
) (
    input  logic            clk,
    input  logic            rst,
    bus_timer_slave_if.slave bus,
    output logic            irq_o
);
    state_t              state_reg, state_next;
    logic                en_reg, auto_reg, irq_en_reg;
    logic                expired_reg, irq_reg;
    logic [WORDSIZE-1:0] load_reg, data_reg, rd_data, count;
    logic                expire, accept, wr, en_next;
    logic [7:0]          off;
    logic                unused_addr;

    assign off         = 8'(bus.addr_i[OFFSET_BITS-1:0]);
    assign unused_addr = ^bus.addr_i[ADDRSIZE-1:OFFSET_BITS];
    assign accept      = (state_reg == ST_IDLE) && bus.hello_i;
    assign wr          = accept && bus.we_i;

`ifdef TIMER_PRESCALER_EN
    logic [WORDSIZE-1:0] prescale_reg;

    always_ff @(posedge clk) begin
        if (rst)
            prescale_reg <= '0;
        else if (wr && off == TMR_PRESCALE)
            prescale_reg <= bus.data_i;
    end
`endif

    timer_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en_reg),
        .auto       (auto_reg),
        .load       (load_reg),
        .wr_count   (wr && off == TMR_COUNT),
        .wr_value   (bus.data_i),
`ifdef TIMER_PRESCALER_EN
        .prescale   (prescale_reg),
        .wr_prescale(wr && off == TMR_PRESCALE),
`endif
        .count      (count),
        .expire     (expire)
    );

    always_comb begin
        rd_data = '0;
        case (off)
            TMR_CTRL:     rd_data = WORDSIZE'({irq_en_reg, auto_reg, en_reg});
            TMR_LOAD:     rd_data = load_reg;
            TMR_COUNT:    rd_data = count;
            TMR_STATUS:   rd_data = WORDSIZE'(expired_reg);
`ifdef TIMER_PRESCALER_EN
            TMR_PRESCALE: rd_data = prescale_reg;
`endif
            default:      rd_data = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.hello_i)  state_next = ST_ACK;
            ST_ACK:  if (!bus.hello_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One-shot expiry stops the timer unless the bus writes CTRL this edge.
    always_comb begin
        en_next = en_reg;
        if (expire && !auto_reg)
            en_next = 1'b0;
        if (wr && off == TMR_CTRL)
            en_next = bus.data_i[CTRL_EN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            en_reg      <= 1'b0;
            auto_reg    <= 1'b0;
            irq_en_reg  <= 1'b0;
            load_reg    <= RESET_LOAD;
            expired_reg <= 1'b0;
            irq_reg     <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            en_reg    <= en_next;
            irq_reg   <= expired_reg & irq_en_reg;
            if (wr && off == TMR_CTRL) begin
                auto_reg   <= bus.data_i[CTRL_AUTO];
                irq_en_reg <= bus.data_i[CTRL_IRQ_EN];
            end
            if (wr && off == TMR_LOAD)
                load_reg <= bus.data_i;
            // Set beats write-1-to-clear on a coincident expiry.
            if (expire)
                expired_reg <= 1'b1;
            else if (wr && off == TMR_STATUS && bus.data_i[0])
                expired_reg <= 1'b0;
            if (accept && !bus.we_i)
                data_reg <= rd_data;
        end
    end

    assign bus.ack_o  = (state_reg == ST_ACK);
    assign bus.data_o = data_reg;
    assign irq_o      = irq_reg;
endmodule
